ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single SDRAM model request port between two requesters:
  - the CPU memory path (instruction fetch, data access, cache-line fill);
  - the DMA block (single accesses and bursts).
- Owns the ram_ena / ram_rnw / ram_be / ram_dataWrite / ram_dma / ram_iscache / ram_cntDMA drive.
- Routes ram_done back to the requester currently granted.
- Applies alternating priority on conflict and runs a per-access watchdog.

Parameters:
- ADDR_W, 23, width of ram_Adr; SDRAM address is {2'b00, ram_Adr}.
- CNT_W, 10, width of DMA burst word count.
- TIMEOUT, 1023, max clk1x cycles from ram_ena to ram_done before error.

Ports:
- clk1x  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request; held high with stable payload until cpu_grant.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_isCache  in  1  request is a cache-line fill.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_be  in  4  CPU byte enables.
- cpu_data  in  32  CPU write data.
- cpu_grant  out  1  one-cycle pulse: CPU request accepted.
- cpu_done  out  1  one-cycle pulse: CPU access finished.
- dma_req  in  1  DMA request; held high with stable payload until dma_grant.
- dma_rnw  in  1  1 = read, 0 = write.
- dma_addr  in  ADDR_W  DMA address.
- dma_cnt  in  CNT_W  burst length in words; 0 is treated as 1.
- dma_data  in  32  DMA write data.
- dma_grant  out  1  one-cycle pulse: DMA request accepted.
- dma_done  out  1  one-cycle pulse: DMA access finished.
- ram_ena  out  1  one-cycle request strobe to the SDRAM model.
- ram_rnw  out  1  registered access direction.
- ram_Adr  out  ADDR_W  registered address.
- ram_be  out  4  registered byte enables.
- ram_dataWrite  out  32  registered write data.
- ram_dma  out  1  access belongs to DMA.
- ram_iscache  out  1  access is a cache fill.
- ram_cntDMA  out  CNT_W  registered burst count.
- ram_done  in  1  SDRAM access complete.
- busy  out  1  state is not IDLE.
- error  out  1  sticky watchdog error.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE; last_winner = CPU, so DMA wins the first conflict.
  - Watchdog counter is 0; error is cleared.
- States: IDLE, CPU_ACT, DMA_ACT.
- IDLE → CPU_ACT / DMA_ACT:
  - cpu_req and dma_req are sampled on cycle N.
  - Winner selection:
    - only one request high → that requester wins;
    - both high → the requester that was NOT last_winner wins.
  - On cycle N+1, all of the following happen together:
    - ram_ena = 1 for exactly one cycle;
    - the winner's grant pulses;
    - payload is registered into the ram_* outputs;
    - state moves to CPU_ACT or DMA_ACT;
    - last_winner is updated.
- Payload mapping:
  - CPU wins: ram_dma = 0, ram_iscache = cpu_isCache, ram_be = cpu_be, ram_cntDMA = 0.
  - DMA wins: ram_dma = 1, ram_iscache = 0, ram_be = 4'hF, ram_cntDMA = max(dma_cnt, 1).
- ram_* payload outputs hold their value until the next grant. They do not return to 0 after an access.
- CPU_ACT / DMA_ACT:
  - Requests are ignored while in these states.
  - On ram_done:
    - the owner's done pulses in the same cycle (combinational from ram_done and state);
    - the next state is IDLE.
  - The earliest next ram_ena is therefore 2 cycles after ram_done: back to IDLE, then sample, then issue.
- ram_done while in IDLE is ignored: no done pulse, no state change.
- Watchdog:
  - The counter clears on every grant and increments each cycle in CPU_ACT / DMA_ACT.
  - When the counter reaches TIMEOUT without ram_done:
    - error is set (sticky until reset);
    - the owner's done pulses once (forced release);
    - state returns to IDLE.
  - The counter saturates; it never wraps.
- A request dropped before its grant is legal and produces no access. A request is sampled only in IDLE.
- Reset asserted mid-access:
  - state returns to IDLE and no done pulse is emitted;
  - a ram_done arriving later is ignored because the state is IDLE.
- busy = (state != IDLE).

Test Plan:
- CPU read only: cpu_req = 1, rnw = 1, addr = 0x001000, be = 0xF; ram_done 5 cycles after ram_ena → cpu_grant and ram_ena on cycle N+1, ram_dma = 0, cpu_done coincides with ram_done, dma_done never pulses.
- Conflict fairness: both requests held continuously, ram_done 3 cycles after each ram_ena → grants alternate DMA, CPU, DMA, CPU, starting with DMA after reset.
- DMA burst: dma_cnt = 0 → ram_cntDMA = 1; dma_cnt = 256 → ram_cntDMA = 256 with ram_dma = 1 and ram_be = 0xF.
- Cache fill: cpu_isCache = 1 → ram_iscache = 1; a following DMA grant → ram_iscache = 0.
- Watchdog: TIMEOUT = 15, grant with no ram_done → at count 15 error = 1, one forced done pulse, state IDLE; error stays 1 across a later normal access; reset clears it.
- Reset mid-access: reset while in DMA_ACT, ram_done 2 cycles later → no dma_done, busy = 0, and the next cpu_req is granted normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter (CPU memory path, DMA) for the single SDRAM request port.
// Alternating priority on conflict, registered request payload, per-access watchdog.
module ram_port_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk1x,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic              cpu_isCache,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_data,
    output logic              cpu_grant,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_rnw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [CNT_W-1:0]  dma_cnt,
    input  logic [31:0]       dma_data,
    output logic              dma_grant,
    output logic              dma_done,
    output logic              ram_ena,
    output logic              ram_rnw,
    output logic [ADDR_W-1:0] ram_Adr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_dataWrite,
    output logic              ram_dma,
    output logic              ram_iscache,
    output logic [CNT_W-1:0]  ram_cntDMA,
    input  logic              ram_done,
    output logic              busy,
    output logic              error,
    output logic [1:0]        state_dbg
);
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACT = 2'd1,
        DMA_ACT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            last_dma;
    logic            issue;
    logic            pick_dma;
    logic            wd_expired;
    logic            timeout_hit;
    logic [WD_W-1:0] wd_cnt;

    // Handshake: cpu_req/dma_req are held with a stable payload until the matching
    // one-cycle grant; the grant cycle is also the single ram_ena cycle, and the
    // owner's done pulses combinationally in the cycle ram_done (or a timeout) ends it.
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
    assign issue      = (state == IDLE) && (cpu_req || dma_req);
    // On conflict the side that did not win last time goes first.
    assign pick_dma   = dma_req && (!cpu_req || !last_dma);
    assign wd_expired = (wd_cnt == WD_MAX);

    always_ff @(posedge clk1x) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cpu_done    = 1'b0;
        dma_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = pick_dma ? DMA_ACT : CPU_ACT;
                end
            end
            CPU_ACT: begin
                if (ram_done || wd_expired) begin
                    cpu_done    = 1'b1;
                    timeout_hit = !ram_done;
                    state_next  = IDLE;
                end
            end
            DMA_ACT: begin
                if (ram_done || wd_expired) begin
                    dma_done    = 1'b1;
                    timeout_hit = !ram_done;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // An access abandoned by reset never reports completion.
        if (reset) begin
            cpu_done    = 1'b0;
            dma_done    = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            ram_ena       <= 1'b0;
            cpu_grant     <= 1'b0;
            dma_grant     <= 1'b0;
            ram_rnw       <= 1'b0;
            ram_Adr       <= '0;
            ram_be        <= 4'h0;
            ram_dataWrite <= 32'h0;
            ram_dma       <= 1'b0;
            ram_iscache   <= 1'b0;
            ram_cntDMA    <= '0;
            last_dma      <= 1'b0;
            wd_cnt        <= '0;
            error         <= 1'b0;
        end else begin
            ram_ena   <= 1'b0;
            cpu_grant <= 1'b0;
            dma_grant <= 1'b0;
            if (issue) begin
                ram_ena  <= 1'b1;
                last_dma <= pick_dma;
                wd_cnt   <= '0;
                if (pick_dma) begin
                    dma_grant     <= 1'b1;
                    ram_rnw       <= dma_rnw;
                    ram_Adr       <= dma_addr;
                    ram_be        <= 4'hF;
                    ram_dataWrite <= dma_data;
                    ram_dma       <= 1'b1;
                    ram_iscache   <= 1'b0;
                    ram_cntDMA    <= (dma_cnt == '0) ? CNT_W'(1) : dma_cnt;
                end else begin
                    cpu_grant     <= 1'b1;
                    ram_rnw       <= cpu_rnw;
                    ram_Adr       <= cpu_addr;
                    ram_be        <= cpu_be;
                    ram_dataWrite <= cpu_data;
                    ram_dma       <= 1'b0;
                    ram_iscache   <= cpu_isCache;
                    ram_cntDMA    <= '0;
                end
            end else if (state != IDLE && !wd_expired) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (timeout_hit) begin
                error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: random and directed requests, an SDRAM responder with
// programmable latency, and a negedge monitor checking against a queue-based model.
module tb_ram_port_arbiter;
    localparam int ADDR_W  = 23;
    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 15;
    localparam int W       = 72;

    logic              clk1x = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req, cpu_rnw, cpu_isCache;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_be;
    logic [31:0]       cpu_data;
    logic              cpu_grant, cpu_done;
    logic              dma_req, dma_rnw;
    logic [ADDR_W-1:0] dma_addr;
    logic [CNT_W-1:0]  dma_cnt;
    logic [31:0]       dma_data;
    logic              dma_grant, dma_done;
    logic              ram_ena, ram_rnw, ram_dma, ram_iscache, ram_done;
    logic [ADDR_W-1:0] ram_Adr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_dataWrite;
    logic [CNT_W-1:0]  ram_cntDMA;
    logic              busy, error;
    logic [1:0]        state_dbg;
    logic [W-1:0]      ram_payload;

    always #5 clk1x = ~clk1x;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk1x(clk1x), .reset(reset),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_isCache(cpu_isCache),
        .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_data(cpu_data),
        .cpu_grant(cpu_grant), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
        .dma_cnt(dma_cnt), .dma_data(dma_data),
        .dma_grant(dma_grant), .dma_done(dma_done),
        .ram_ena(ram_ena), .ram_rnw(ram_rnw), .ram_Adr(ram_Adr), .ram_be(ram_be),
        .ram_dataWrite(ram_dataWrite), .ram_dma(ram_dma), .ram_iscache(ram_iscache),
        .ram_cntDMA(ram_cntDMA), .ram_done(ram_done),
        .busy(busy), .error(error), .state_dbg(state_dbg)
    );

    assign ram_payload = {ram_dma, ram_iscache, ram_rnw, ram_be, ram_cntDMA, ram_Adr, ram_dataWrite};

    // Scoreboard and reference model state
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic         m_last_dma = 1'b0;
    logic         m_active = 1'b0;
    logic         m_owner_dma = 1'b0;
    logic         m_err = 1'b0;
    int           m_age = 0;
    int           resp_lat = 0;
    int           kick_req = 0;
    int           kick_seen = 0;
    logic [W-1:0] mon_exp;
    logic         mon_c, mon_d, mon_forced;

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] exp_cpu();
        return {1'b0, cpu_isCache, cpu_rnw, cpu_be, 10'd0, cpu_addr, cpu_data};
    endfunction

    function automatic logic [W-1:0] exp_dma();
        logic [CNT_W-1:0] words;
        words = (dma_cnt == 10'd0) ? 10'd1 : dma_cnt;
        return {1'b1, 1'b0, dma_rnw, 4'hF, words, dma_addr, dma_data};
    endfunction

    // Winner rule: a lone requester wins; on conflict the one that did not win last.
    function automatic logic model_pick(input logic c, input logic d);
        if (c && d) return (m_last_dma == 1'b0);
        return d;
    endfunction

    // SDRAM responder: ram_done resp_lat cycles after ram_ena (never if negative),
    // or a lone pulse whenever kick_req is bumped.
    initial begin
        ram_done = 1'b0;
        forever begin
            @(posedge clk1x);
            #2;
            ram_done = 1'b0;
            if (kick_req != kick_seen) begin
                kick_seen = kick_req;
                ram_done  = 1'b1;
            end else if (ram_ena && resp_lat >= 0) begin
                repeat (resp_lat) begin
                    @(posedge clk1x);
                    #2;
                end
                ram_done = 1'b1;
            end
        end
    end

    // Monitor: pops an expected payload on every ram_ena and tracks the access lifetime.
    always @(negedge clk1x) begin
        if (reset) begin
            check_bit("done_in_reset", cpu_done | dma_done, 1'b0);
            m_active = 1'b0;
            m_err    = 1'b0;
        end else begin
            if (ram_ena) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ram_ena: got payload %0h expected no access", ram_payload);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_vec("ram_payload", ram_payload, mon_exp);
                    check_bit("cpu_grant", cpu_grant, !mon_exp[W-1]);
                    check_bit("dma_grant", dma_grant, mon_exp[W-1]);
                    m_active    = 1'b1;
                    m_owner_dma = mon_exp[W-1];
                    m_age       = 0;
                end
            end else begin
                check_bit("stray_grant", cpu_grant | dma_grant, 1'b0);
                if (m_active) m_age++;
            end
            check_bit("busy", busy, m_active);
            mon_c      = 1'b0;
            mon_d      = 1'b0;
            mon_forced = 1'b0;
            if (m_active && (ram_done || m_age == TIMEOUT)) begin
                mon_d      = m_owner_dma;
                mon_c      = !m_owner_dma;
                mon_forced = !ram_done;
            end
            check_bit("cpu_done", cpu_done, mon_c);
            check_bit("dma_done", dma_done, mon_d);
            check_bit("error", error, m_err);
            if (mon_forced) m_err = 1'b1;
            if (mon_c || mon_d) m_active = 1'b0;
        end
    end

    task automatic set_cpu(input logic rnw, input logic [ADDR_W-1:0] addr, input logic [3:0] be, input logic isc);
        cpu_rnw     = rnw;
        cpu_addr    = addr;
        cpu_be      = be;
        cpu_isCache = isc;
        cpu_data    = $urandom;
    endtask

    task automatic set_dma(input logic rnw, input logic [ADDR_W-1:0] addr, input logic [CNT_W-1:0] cnt);
        dma_rnw  = rnw;
        dma_addr = addr;
        dma_cnt  = cnt;
        dma_data = $urandom;
    endtask

    task automatic rand_cpu();
        set_cpu(1'($urandom_range(0, 1)), ADDR_W'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic rand_dma();
        set_dma(1'($urandom_range(0, 1)), ADDR_W'($urandom),
                ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)));
    endtask

    task automatic wait_grant(input logic want_dma, output logic got_dma);
        logic ok;
        ok      = 1'b0;
        got_dma = !want_dma;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk1x);
            #1;
            if (want_dma ? dma_grant : cpu_grant) begin
                ok      = 1'b1;
                got_dma = want_dma;
                break;
            end
        end
        check_bit(want_dma ? "dma_grant_seen" : "cpu_grant_seen", ok, 1'b1);
    endtask

    task automatic wait_release();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk1x);
            if (!m_active) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        check_bit("access_released", ok, 1'b1);
    endtask

    task automatic push_winner(input logic w);
        exp_q.push_back(w ? exp_dma() : exp_cpu());
        m_last_dma = w;
    endtask

    // Raise the chosen requests and serve them one by one until both are dropped.
    task automatic run(input logic want_c, input logic want_d, input int lat);
        logic w, got;
        resp_lat = lat;
        cpu_req  = want_c;
        dma_req  = want_d;
        while (cpu_req || dma_req) begin
            w = model_pick(cpu_req, dma_req);
            push_winner(w);
            wait_grant(w, got);
            if (w) dma_req = 1'b0;
            else   cpu_req = 1'b0;
            wait_release();
        end
    endtask

    task automatic do_reset();
        @(posedge clk1x);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk1x);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_last_dma = 1'b0;
    endtask

    logic       got_w;
    logic [3:0] order;

    initial begin
        cpu_req = 0; cpu_rnw = 0; cpu_isCache = 0; cpu_addr = '0; cpu_be = 0; cpu_data = 0;
        dma_req = 0; dma_rnw = 0; dma_addr = '0; dma_cnt = '0; dma_data = 0;
        repeat (3) @(posedge clk1x);
        #1;
        check_vec("reset_payload", ram_payload, '0);
        check_vec("reset_ctrl", W'({ram_ena, cpu_grant, dma_grant, cpu_done, dma_done, busy, error, state_dbg}), '0);
        reset = 1'b0;

        // CPU read only
        set_cpu(1'b1, 23'h001000, 4'hF, 1'b0);
        run(1'b1, 1'b0, 5);

        // Both held continuously: DMA first after reset, then alternating
        do_reset();
        rand_cpu();
        rand_dma();
        resp_lat = 3;
        cpu_req  = 1'b1;
        dma_req  = 1'b1;
        order    = 4'b0;
        for (int k = 0; k < 4; k++) begin
            got_w = model_pick(cpu_req, dma_req);
            push_winner(got_w);
            wait_grant(got_w, got_w);
            order = {order[2:0], got_w};
            if (k == 3) begin
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end else if (got_w) begin
                rand_dma();
            end else begin
                rand_cpu();
            end
            wait_release();
        end
        check_vec("fair_order", W'(order), W'(4'b1010));

        // DMA burst length: 0 counts as one word
        set_dma(1'b1, 23'h000200, 10'd0);
        run(1'b0, 1'b1, 2);
        set_dma(1'b0, 23'h7FFF00, 10'd256);
        run(1'b0, 1'b1, 4);

        // Cache fill followed by a DMA access
        set_cpu(1'b1, 23'h012340, 4'hF, 1'b1);
        run(1'b1, 1'b0, 1);
        rand_dma();
        run(1'b0, 1'b1, 0);

        // Stray ram_done while idle
        @(posedge clk1x);
        #1;
        kick_req++;
        repeat (3) @(posedge clk1x);
        #1;

        for (int i = 0; i < 24; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_cpu();
            rand_dma();
            run(1'(pat), 1'(pat >> 1), $urandom_range(0, 6));
        end

        // Watchdog: no response, forced release, sticky error
        rand_cpu();
        run(1'b1, 1'b0, -1);
        check_bit("error_after_timeout", error, 1'b1);
        rand_dma();
        run(1'b0, 1'b1, 2);
        check_bit("error_sticky", error, 1'b1);
        do_reset();
        check_bit("error_cleared", error, 1'b0);

        // Reset in the middle of a DMA access, ram_done arriving afterwards
        rand_dma();
        resp_lat = 3;
        dma_req  = 1'b1;
        push_winner(1'b1);
        wait_grant(1'b1, got_w);
        dma_req = 1'b0;
        @(posedge clk1x);
        #1;
        reset = 1'b1;
        @(posedge clk1x);
        #1;
        reset      = 1'b0;
        m_last_dma = 1'b0;
        check_bit("busy_after_reset", busy, 1'b0);
        repeat (4) @(posedge clk1x);
        #1;
        rand_cpu();
        run(1'b1, 1'b0, 3);

        repeat (3) @(posedge clk1x);
        check_vec("exp_q_drained", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within 50000 cycles");
        $fatal(1);
    end
endmodule
